aes_decrypt: RTL

Byte-serial AES-128 inverse cipher: the receive-side counterpart of the byte-serial `encrypt` core. Accepts a 16-byte ciphertext block and a 176-byte stream of pre-expanded round keys (supplied last round first), one byte per clock, and produces the 128-bit plaintext. It sits between the link/storage byte interface and the plaintext consumer. A single inverse S-box is time-shared across all bytes.

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/inv_sbox.sv | 26 ++
 rtl/aes_decrypt.sv | 129 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the byte-serial inverse cipher: FSM encoding,
// GF(2^8) helpers and the InvShiftRows byte map.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_INV_SR,
        ST_INV_SB,
        ST_ARK,
        ST_INV_MC,
        ST_DONE
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant; covers the 09/0b/0d/0e InvMixColumns terms.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int k = 0; k < 4; k++) begin
            if (c[k]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Source byte for state byte i (row = i[1:0], column = i[3:2]) after
    // rotating row r right by r positions.
    function automatic logic [3:0] inv_sr_src(input logic [3:0] i);
        logic [1:0] r;
        logic [1:0] c;
        r = i[1:0];
        c = i[3:2];
        return {2'(c - r), r};
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box, one byte per lookup.
module inv_sbox (
    input  logic [7:0] value,
    output logic [7:0] result
);
    localparam logic [7:0] TBL [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign result = TBL[value];
endmodule

// File: rtl/aes_decrypt.sv
// Byte-serial AES-128 inverse cipher: ciphertext and round keys (last round
// first) arrive one byte per clock; a single inverse S-box is time-shared.
module aes_decrypt
    import aes_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [7:0]   in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   key,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         done,
    output logic [127:0] message
);
    state_t       state;
    logic [3:0]   cnt;
    logic [3:0]   rnd;
    logic [7:0]   cur_byte;
    logic [7:0]   sb_byte;
    logic [127:0] sr_state;
    logic [7:0]   col_in  [4];
    logic [7:0]   col_out [4];

    assign in_ready  = (state == ST_LOAD);
    assign key_ready = (state == ST_LOAD) || (state == ST_ARK);

    // Byte i lives at message[127-8i -: 8], i.e. bit offset {~i, 3'b111}.
    assign cur_byte = message[{~cnt, 3'b111} -: 8];

    inv_sbox u_inv_sbox (
        .value  (cur_byte),
        .result (sb_byte)
    );

    always_comb begin
        sr_state = message;
        for (int i = 0; i < 16; i++)
            sr_state[{~4'(i), 3'b111} -: 8] = message[{~inv_sr_src(4'(i)), 3'b111} -: 8];
    end

    always_comb begin
        for (int k = 0; k < 4; k++)
            col_in[k] = message[{~cnt[1:0], ~2'(k), 3'b111} -: 8];
        col_out[0] = gmul(col_in[0], 4'he) ^ gmul(col_in[1], 4'hb) ^ gmul(col_in[2], 4'hd) ^ gmul(col_in[3], 4'h9);
        col_out[1] = gmul(col_in[0], 4'h9) ^ gmul(col_in[1], 4'he) ^ gmul(col_in[2], 4'hb) ^ gmul(col_in[3], 4'hd);
        col_out[2] = gmul(col_in[0], 4'hd) ^ gmul(col_in[1], 4'h9) ^ gmul(col_in[2], 4'he) ^ gmul(col_in[3], 4'hb);
        col_out[3] = gmul(col_in[0], 4'hb) ^ gmul(col_in[1], 4'hd) ^ gmul(col_in[2], 4'h9) ^ gmul(col_in[3], 4'he);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            rnd     <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            message <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_LOAD;
                        cnt   <= 4'd0;
                        rnd   <= 4'(NR - 1);
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (in_valid && key_valid) begin
                        message[{~cnt, 3'b111} -: 8] <= in ^ key;
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) state <= ST_INV_SR;
                    end
                end
                ST_INV_SR: begin
                    message <= sr_state;
                    state   <= ST_INV_SB;
                end
                ST_INV_SB: begin
                    message[{~cnt, 3'b111} -: 8] <= sb_byte;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) state <= ST_ARK;
                end
                ST_ARK: begin
                    if (key_valid) begin
                        message[{~cnt, 3'b111} -: 8] <= cur_byte ^ key;
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            if (rnd == 4'd0) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_INV_MC;
                            end
                        end
                    end
                end
                ST_INV_MC: begin
                    for (int k = 0; k < 4; k++)
                        message[{~cnt[1:0], ~2'(k), 3'b111} -: 8] <= col_out[k];
                    if (cnt == 4'd3) begin
                        cnt   <= 4'd0;
                        rnd   <= rnd - 4'd1;
                        state <= ST_INV_SR;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    // A start raised alongside done chains the next block with no idle gap.
                    if (start) begin
                        state <= ST_LOAD;
                        cnt   <= 4'd0;
                        rnd   <= 4'(NR - 1);
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
